// File: rtl/icache_req_arb.sv
// icache_req_arb: shares the icache request/response port pair among fetch requesters.
// Define ICACHE_REQ_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest).
module icache_req_arb #(
  parameter int NUM_REQ         = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int TXNID_WIDTH     = 4,
  parameter int DATA_WIDTH      = 256,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_vld,
  output logic [NUM_REQ-1:0]                req_rdy,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr,
  output logic [NUM_REQ-1:0]                rsp_vld,
  input  logic [NUM_REQ-1:0]                rsp_rdy,
  output logic [DATA_WIDTH-1:0]             rsp_data,
  output logic                              upstream_rxreq_vld,
  input  logic                              upstream_rxreq_rdy,
  output logic [TXNID_WIDTH+ADDR_WIDTH-1:0] upstream_rxreq_pld,
  input  logic                              upstream_txdat_vld,
  output logic                              upstream_txdat_rdy,
  input  logic [DATA_WIDTH-1:0]             upstream_txdat_data,
  input  logic [TXNID_WIDTH-1:0]            upstream_txdat_txnid,
  input  logic                              flush_req,
  output logic                              flush_done,
  output logic                              err_unexp_txnid
);
  localparam int NTAG = 1 << TXNID_WIDTH;
  localparam int RW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW   = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t                          state_q;
  state_t                          state_d;
  logic                            run;
  logic [NTAG-1:0]                 free_q;
  logic [RW-1:0]                   owner_q [NTAG];
  logic [CW-1:0]                   cnt_q [NUM_REQ];
  logic                            out_vld_q;
  logic [TXNID_WIDTH+ADDR_WIDTH-1:0] out_pld_q;
  logic                            err_q;

  logic                            stage_ok;
  logic                            gnt_any;
  logic [NUM_REQ-1:0]              elig;
  logic [NUM_REQ-1:0]              gnt;
  logic [RW-1:0]                   win;
  logic [RW-1:0]                   cand;
  logic [RW:0]                     sum;
  logic [TXNID_WIDTH-1:0]          tag;
  logic [ADDR_WIDTH-1:0]           addr_sel;
  logic [RW-1:0]                   rsp_owner;
  logic                            txn_alloc;
  logic                            rel;
  logic [NUM_REQ-1:0]              rel_vec;
`ifndef ICACHE_REQ_ARB_FIXED_PRIO_EN
  logic [RW-1:0]                   rr_ptr_q;
`endif

  // a full stage may still take a grant when it hands off this cycle
  assign stage_ok = ~out_vld_q | upstream_rxreq_rdy;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_vld[i] & run & (|free_q) & stage_ok &
                (cnt_q[i] < CW'(MAX_OUTSTANDING));
    end
  end

  always_comb begin
    gnt     = '0;
    win     = '0;
    gnt_any = 1'b0;
    cand    = '0;
    sum     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef ICACHE_REQ_ARB_FIXED_PRIO_EN
      cand = RW'(k);
`else
      sum = {1'b0, rr_ptr_q} + (RW+1)'(k);
      if (sum >= (RW+1)'(NUM_REQ)) sum = sum - (RW+1)'(NUM_REQ);
      cand = sum[RW-1:0];
`endif
      if (!gnt_any && elig[cand]) begin
        gnt_any = 1'b1;
        win     = cand;
      end
    end
    if (gnt_any) gnt[win] = 1'b1;
  end

  assign req_rdy = gnt;

  always_comb begin
    tag = '0;
    for (int t = NTAG - 1; t >= 0; t--) begin
      if (free_q[t]) tag = TXNID_WIDTH'(t);
    end
  end

  always_comb begin
    addr_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) addr_sel = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  assign rsp_owner = owner_q[upstream_txdat_txnid];
  assign txn_alloc = ~free_q[upstream_txdat_txnid];
  assign rsp_data  = upstream_txdat_data;
  // unknown txnids are swallowed so the icache never stalls on them
  assign upstream_txdat_rdy = txn_alloc ? rsp_rdy[rsp_owner] : 1'b1;
  assign rel = upstream_txdat_vld & txn_alloc & rsp_rdy[rsp_owner];

  always_comb begin
    rsp_vld = '0;
    rsp_vld[rsp_owner] = upstream_txdat_vld & txn_alloc;
  end

  always_comb begin
    rel_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rel_vec[i] = rel & (rsp_owner == RW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (flush_req) state_d = DRAIN;
      DRAIN:   if (&free_q && !out_vld_q) state_d = DONE;
      DONE:    if (!flush_req) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    run        = (state_q == RUN);
    flush_done = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      free_q <= '1;
      for (int t = 0; t < NTAG; t++) owner_q[t] <= '0;
    end else begin
      if (gnt_any) begin
        free_q[tag]  <= 1'b0;
        owner_q[tag] <= win;
      end
      if (rel) free_q[upstream_txdat_txnid] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!rst_n)                      cnt_q[i] <= '0;
      else if (gnt[i] && !rel_vec[i])  cnt_q[i] <= cnt_q[i] + 1'b1;
      else if (!gnt[i] && rel_vec[i])  cnt_q[i] <= cnt_q[i] - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0;
      out_pld_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (gnt_any) begin
        out_vld_q <= 1'b1;
        out_pld_q <= {tag, addr_sel};
      end else if (upstream_rxreq_rdy) begin
        out_vld_q <= 1'b0;
      end
      if (upstream_txdat_vld && !txn_alloc) err_q <= 1'b1;
    end
  end

`ifndef ICACHE_REQ_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk) begin
    if (!rst_n)       rr_ptr_q <= '0;
    else if (gnt_any) rr_ptr_q <= (win == RW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
  end
`endif

  assign upstream_rxreq_vld = out_vld_q;
  assign upstream_rxreq_pld = out_pld_q;
  assign err_unexp_txnid    = err_q;

endmodule

// File: tb/tb_icache_req_arb.sv
// tb_icache_req_arb: directed scenarios then a random run for icache_req_arb,
// checked against a tag-pool reference model and scoreboard queues.
`timescale 1ns/1ps
module tb_icache_req_arb;
  localparam int N    = 2;
  localparam int AW   = 32;
  localparam int TW   = 4;
  localparam int DW   = 256;
  localparam int MAXO = 8;
  localparam int NTAG = 1 << TW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_vld = '0;
  logic [N-1:0]    req_rdy;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]    rsp_vld;
  logic [N-1:0]    rsp_rdy = '1;
  logic [DW-1:0]   rsp_data;
  logic            upstream_rxreq_vld;
  logic            upstream_rxreq_rdy = 1'b1;
  logic [TW+AW-1:0] upstream_rxreq_pld;
  logic            upstream_txdat_vld = 1'b0;
  logic            upstream_txdat_rdy;
  logic [DW-1:0]   upstream_txdat_data = '0;
  logic [TW-1:0]   upstream_txdat_txnid = '0;
  logic            flush_req = 1'b0;
  logic            flush_done;
  logic            err_unexp_txnid;

  icache_req_arb #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .TXNID_WIDTH(TW),
    .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_addr(req_addr),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data),
    .upstream_rxreq_vld(upstream_rxreq_vld),
    .upstream_rxreq_rdy(upstream_rxreq_rdy),
    .upstream_rxreq_pld(upstream_rxreq_pld),
    .upstream_txdat_vld(upstream_txdat_vld),
    .upstream_txdat_rdy(upstream_txdat_rdy),
    .upstream_txdat_data(upstream_txdat_data),
    .upstream_txdat_txnid(upstream_txdat_txnid),
    .flush_req(flush_req), .flush_done(flush_done),
    .err_unexp_txnid(err_unexp_txnid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            owner;
    logic [DW-1:0] data;
  } rsp_t;

  logic [TW+AW-1:0] exp_req[$];
  rsp_t             exp_rsp[$];
  rsp_t             mon_e;
  int n_cmp = 0;
  int n_bad = 0;

  // reference model: tag pool, per-requester counts, stage occupancy, mode
  bit m_free [NTAG];
  int m_owner [NTAG];
  int m_cnt [N];
  int m_ptr;
  bit m_full;
  int m_mode;
  bit m_err;

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    for (int t = 0; t < NTAG; t++) begin
      m_free[t]  = 1'b1;
      m_owner[t] = 0;
    end
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_ptr  = 0;
    m_full = 1'b0;
    m_mode = 0;
    m_err  = 1'b0;
    exp_req.delete();
    exp_rsp.delete();
  endtask

  task automatic model_step();
    int win;
    int nfree;
    int tag;
    int o;
    int i;
    int rel_tag;
    bit rel;
    bit full_pre;
    logic [N-1:0] exp_gnt;
    check("err_unexp_txnid", err_unexp_txnid, m_err);
    check("flush_done", flush_done, m_mode == 2);
    check("rxreq_vld", upstream_rxreq_vld, m_full);
    rel = 1'b0;
    rel_tag = 0;
    if (upstream_txdat_vld) begin
      if (!m_free[upstream_txdat_txnid]) begin
        o = m_owner[upstream_txdat_txnid];
        check("txdat_rdy", upstream_txdat_rdy, rsp_rdy[o]);
        check("rsp_vld", rsp_vld, N'(1) << o);
        if (rsp_rdy[o]) begin
          exp_rsp.push_back('{o, upstream_txdat_data});
          rel = 1'b1;
          rel_tag = int'(upstream_txdat_txnid);
        end
      end else begin
        check("txdat_rdy_drop", upstream_txdat_rdy, 1'b1);
        check("rsp_vld_drop", rsp_vld, '0);
        m_err = 1'b1;
      end
    end
    nfree = 0;
    for (int t = 0; t < NTAG; t++) nfree += int'(m_free[t]);
    full_pre = m_full;
    win = -1;
    for (int k = 0; k < N; k++) begin
`ifdef ICACHE_REQ_ARB_FIXED_PRIO_EN
      i = k;
`else
      i = (m_ptr + k) % N;
`endif
      if (win < 0 && req_vld[i] && m_mode == 0 && m_cnt[i] < MAXO &&
          nfree > 0 && (!m_full || upstream_rxreq_rdy)) win = i;
    end
    exp_gnt = (win >= 0) ? (N'(1) << win) : '0;
    check("req_rdy", req_rdy, exp_gnt);
    if (win >= 0) begin
      tag = 0;
      while (!m_free[tag]) tag++;
      exp_req.push_back({TW'(tag), req_addr[win*AW +: AW]});
      m_free[tag]  = 1'b0;
      m_owner[tag] = win;
      m_cnt[win]++;
      m_ptr  = (win + 1) % N;
      m_full = 1'b1;
    end else if (upstream_rxreq_rdy) begin
      m_full = 1'b0;
    end
    case (m_mode)
      0: if (flush_req) m_mode = 1;
      1: if (nfree == NTAG && !full_pre) m_mode = 2;
      default: if (!flush_req) m_mode = 0;
    endcase
    if (rel) begin
      m_free[rel_tag] = 1'b1;
      m_cnt[m_owner[rel_tag]]--;
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (!rst_n) m_reset();
    else        model_step();
  end

  // monitor: pops the scoreboard whenever the DUT completes a handshake
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (upstream_rxreq_vld && upstream_rxreq_rdy) begin
        if (exp_req.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rxreq_extra: got %0h expected none", upstream_rxreq_pld);
        end else begin
          check("rxreq_pld", upstream_rxreq_pld, exp_req.pop_front());
        end
      end
      for (int i = 0; i < N; i++) begin
        if (rsp_vld[i] && rsp_rdy[i]) begin
          if (exp_rsp.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL rsp_extra: got owner %0d expected none", i);
          end else begin
            mon_e = exp_rsp.pop_front();
            check("rsp_owner", i, mon_e.owner);
            check("rsp_data", rsp_data, mon_e.data);
          end
        end
      end
    end
  end

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int w = 0; w < DW / 32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic idle();
    req_vld = '0;
    req_addr = '0;
    rsp_rdy = '1;
    upstream_rxreq_rdy = 1'b1;
    upstream_txdat_vld = 1'b0;
    upstream_txdat_txnid = '0;
    upstream_txdat_data = '0;
    flush_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_dat(input int txnid);
    upstream_txdat_vld = 1'b1;
    upstream_txdat_txnid = TW'(txnid);
    upstream_txdat_data = rnd_data();
  endtask

  int list[$];
  int fl_cnt;
  bit ok;
  logic [N-1:0] exp_v;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    idle();
    do_reset();
    #3;
    check("rst_req_rdy", req_rdy, '0);
    check("rst_rsp_vld", rsp_vld, '0);
    check("rst_rxreq_vld", upstream_rxreq_vld, 1'b0);
    check("rst_rxreq_pld", upstream_rxreq_pld, '0);
    check("rst_flush_done", flush_done, 1'b0);
    check("rst_err", err_unexp_txnid, 1'b0);

    // single request
    @(negedge clk);
    req_vld = 2'b01;
    req_addr[0 +: AW] = 32'h1000;
    #3 check("single_gnt", req_rdy, 2'b01);
    @(negedge clk);
    req_vld = '0;
    #3;
    check("single_vld", upstream_rxreq_vld, 1'b1);
    check("single_pld", upstream_rxreq_pld, {4'h0, 32'h1000});
    @(negedge clk);
    send_dat(0);
    #3;
    check("single_rsp_vld", rsp_vld, 2'b01);
    check("single_dat_rdy", upstream_txdat_rdy, 1'b1);
    @(negedge clk);
    upstream_txdat_vld = 1'b0;

    // both requesters valid: arbitration order and txnids
    do_reset();
    req_vld = '1;
    for (int g = 0; g < 8; g++) begin
`ifdef ICACHE_REQ_ARB_FIXED_PRIO_EN
      exp_v = 2'b01;
`else
      exp_v = (g % 2 == 0) ? 2'b01 : 2'b10;
`endif
      #3 check("alt_gnt", req_rdy, exp_v);
      if (g > 0) check("alt_txnid", upstream_rxreq_pld[TW+AW-1:AW], TW'(g - 1));
      @(negedge clk);
    end

    // keep requesting with no responses until the pool runs dry
    repeat (12) @(negedge clk);
    #3 check("pool_empty_stall", req_rdy, '0);
    @(negedge clk);
    send_dat(3);
    #3 check("pool_free_cycle", req_rdy, '0);
    @(negedge clk);
    upstream_txdat_vld = 1'b0;
    #3 check("pool_resume", |req_rdy, 1'b1);
    @(negedge clk);
    req_vld = '0;

    // upstream back-pressure holds the stage
    do_reset();
    upstream_rxreq_rdy = 1'b0;
    req_vld = 2'b01;
    req_addr[0 +: AW] = 32'hABC0;
    #3 check("bp_first_gnt", req_rdy, 2'b01);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #3;
      check("bp_vld", upstream_rxreq_vld, 1'b1);
      check("bp_pld", upstream_rxreq_pld, {4'h0, 32'hABC0});
      check("bp_no_gnt", req_rdy, '0);
    end
    @(negedge clk);
    upstream_rxreq_rdy = 1'b1;
    #3 check("bp_release_gnt", req_rdy, 2'b01);
    @(negedge clk);
    req_vld = '0;

    // out-of-order return with a stalled owner
    do_reset();
    req_vld = 2'b01;
    @(negedge clk);
    req_vld = 2'b10;
    @(negedge clk);
    req_vld = '0;
    repeat (2) @(negedge clk);
    rsp_rdy = 2'b01;
    send_dat(1);
    #3;
    check("ooo_hold_rdy", upstream_txdat_rdy, 1'b0);
    check("ooo_hold_vld", rsp_vld, 2'b10);
    @(negedge clk);
    rsp_rdy = 2'b11;
    #3;
    check("ooo_go_rdy", upstream_txdat_rdy, 1'b1);
    check("ooo_go_vld", rsp_vld, 2'b10);
    @(negedge clk);
    send_dat(0);
    @(negedge clk);
    upstream_txdat_vld = 1'b0;

    // flush with three tags in flight
    do_reset();
    req_vld = 2'b01;
    repeat (3) @(negedge clk);
    req_vld = '0;
    flush_req = 1'b1;
    @(negedge clk);
    req_vld = '1;
    for (int t = 0; t < 3; t++) begin
      repeat (2) @(negedge clk);
      #3;
      check("flush_no_gnt", req_rdy, '0);
      check("flush_not_done", flush_done, 1'b0);
      @(negedge clk);
      send_dat(t);
      @(negedge clk);
      upstream_txdat_vld = 1'b0;
    end
    ok = 1'b0;
    for (int w = 0; w < 6 && !ok; w++) begin
      @(negedge clk);
      #3 ok = flush_done;
    end
    check("flush_done_rise", ok, 1'b1);
    check("flush_done_no_gnt", req_rdy, '0);
    @(negedge clk);
    send_dat(5);
    #3 check("unexp_dat_rdy", upstream_txdat_rdy, 1'b1);
    @(negedge clk);
    upstream_txdat_vld = 1'b0;
    #3 check("unexp_err_set", err_unexp_txnid, 1'b1);
    @(negedge clk);
    flush_req = 1'b0;
    req_vld = '0;
    do_reset();
    #3 check("err_cleared", err_unexp_txnid, 1'b0);

    // random traffic
    fl_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      else @(negedge clk);
      req_vld = N'($urandom);
      for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = $urandom;
      upstream_rxreq_rdy = ($urandom_range(0, 9) < 7);
      rsp_rdy = N'($urandom);
      if (fl_cnt > 0) begin
        fl_cnt--;
        flush_req = 1'b1;
      end else begin
        flush_req = 1'b0;
        if ($urandom_range(0, 99) == 0) fl_cnt = $urandom_range(20, 60);
      end
      list.delete();
      for (int t = 0; t < NTAG; t++) if (!m_free[t]) list.push_back(t);
      if (list.size() > 0 && $urandom_range(0, 1) == 1)
        send_dat(list[$urandom_range(0, list.size() - 1)]);
      else
        upstream_txdat_vld = 1'b0;
    end

    // drain everything still in flight
    @(negedge clk);
    idle();
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      list.delete();
      for (int t = 0; t < NTAG; t++) if (!m_free[t]) list.push_back(t);
      if (list.size() > 0) send_dat(list[0]);
      else upstream_txdat_vld = 1'b0;
    end
    @(negedge clk);
    upstream_txdat_vld = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    check("sb_req_empty", exp_req.size(), 0);
    check("sb_rsp_empty", exp_rsp.size(), 0);
    check("end_rxreq_idle", upstream_rxreq_vld, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
